// File: rtl/spi_crc_pkg.sv
// rtl/spi_crc_pkg.sv - shared types and defaults for the CRC frame-check sequencer
package spi_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } crc_ctrl_state_t;

  localparam int DEF_WCODE = 3;
  localparam int DEF_WPOLY = 4;
  localparam int DEF_WLEN  = 4;

  // Remainder width is one bit narrower than the divisor.
  function automatic int crc_width(input int wpoly);
    return wpoly - 1;
  endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - one fold of a WCODE-bit word into the running remainder
// Bitwise GF(2) long division of {data, rem} by poly; all XOR, no carries.
module crc_step #(
  parameter int WCODE = 3,
  parameter int WPOLY = 4
) (
  input  logic [WCODE-1:0] i_data,
  input  logic [WPOLY-2:0] i_rem,
  input  logic [WPOLY-1:0] i_poly,
  output logic [WPOLY-2:0] o_rem
);

  localparam int WT = WCODE + WPOLY - 1;

  logic [WT-1:0] t;
  logic [WT-1:0] q;

  always_comb begin
    t = {i_data, i_rem};
    q = WT'(i_poly) << (WCODE - 1);
    for (int i = WCODE - 1; i >= 0; i--) begin
      if (t[i+WPOLY-1]) begin
        t = t ^ q;
      end
      q = q >> 1;
    end
    o_rem = t[WPOLY-2:0];
  end

endmodule

// File: rtl/crc_frame_check_ctrl.sv
// rtl/crc_frame_check_ctrl.sv - frame sequencer: folds words into a remainder and checks it
// All outputs are registered; ready and busy follow the state only.
module crc_frame_check_ctrl
  import spi_crc_pkg::*;
#(
  parameter int WCODE = DEF_WCODE,
  parameter int WPOLY = DEF_WPOLY,
  parameter int WLEN  = DEF_WLEN
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [WPOLY-1:0]   i_poly,
  input  logic [WLEN-1:0]    i_len,
  input  logic [WPOLY-2:0]   i_crc_exp,
  input  logic [WCODE-1:0]   i_data,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [WPOLY-2:0]   o_crc,
  output logic               o_match,
  output logic               o_err
);

  localparam int WCRC = crc_width(WPOLY);

  crc_ctrl_state_t  state_q;
  logic [WPOLY-1:0] poly_q;
  logic [WCRC-1:0]  crc_exp_q;
  logic [WCRC-1:0]  rem_q;
  logic [WCRC-1:0]  crc_q;
  logic [WLEN-1:0]  cnt_q;
  logic             done_q;
  logic             match_q;
  logic             err_q;
  logic             ready_q;
  logic             busy_q;
  logic [WCRC-1:0]  step_rem;
  logic             xfer;

  assign xfer = i_data_valid & ready_q;

  crc_step #(
    .WCODE (WCODE),
    .WPOLY (WPOLY)
  ) u_step (
    .i_data (i_data),
    .i_rem  (rem_q),
    .i_poly (poly_q),
    .o_rem  (step_rem)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      poly_q    <= '0;
      crc_exp_q <= '0;
      rem_q     <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            poly_q    <= i_poly;
            crc_exp_q <= i_crc_exp;
            rem_q     <= '0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            // A divisor without its top bit cannot define a CRC of this width.
            if (!i_poly[WPOLY-1]) begin
              err_q   <= 1'b1;
              crc_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (i_len == '0) begin
              crc_q   <= '0;
              match_q <= (i_crc_exp == '0);
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= i_len;
              ready_q <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (i_abort) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (xfer) begin
            rem_q <= step_rem;
            cnt_q <= cnt_q - WLEN'(1);
            if (cnt_q == WLEN'(1)) begin
              crc_q   <= step_rem;
              match_q <= (step_rem == crc_exp_q);
              done_q  <= 1'b1;
              ready_q <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_data_ready = ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_crc        = crc_q;
  assign o_match      = match_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_crc_frame_check_ctrl.sv
// tb/tb_crc_frame_check_ctrl.sv - self-checking bench for crc_frame_check_ctrl
// Expected remainders come from GF(2) polynomial modulo arithmetic on each word.
module tb_crc_frame_check_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] poly = 4'b1011;
  logic [3:0] len = 4'd0;
  logic [2:0] cexp = 3'd0;
  logic [2:0] data = 3'd0;
  logic       valid = 1'b0;
  logic       ready, busy, done, match, err;
  logic [2:0] crc;

  int errors = 0;
  int checks = 0;
  logic [2:0] words[$];

  always #5 clk = ~clk;

  crc_frame_check_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_poly       (poly),
    .i_len        (len),
    .i_crc_exp    (cexp),
    .i_data       (data),
    .i_data_valid (valid),
    .o_data_ready (ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_crc        (crc),
    .o_match      (match),
    .o_err        (err)
  );

  // ({d, r} as a degree-5 polynomial) mod p, where p has degree 3.
  function automatic logic [2:0] model_step(input logic [2:0] d, input logic [2:0] r,
                                            input logic [3:0] p);
    int t;
    t = int'({d, r});
    for (int b = 5; b >= 3; b--) begin
      if (t[b]) t = t ^ (int'(p) << (b - 3));
    end
    return t[2:0];
  endfunction

  function automatic logic [2:0] model_frame(input logic [3:0] p, input int n);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < n; k++) r = model_step(words[k], r, p);
    return r;
  endfunction

  task automatic do_frame(input string name, input logic [3:0] p, input logic [3:0] n,
                          input logic [2:0] ce, input int gmin, input int gmax);
    logic       e_err;
    logic [2:0] e_crc;
    logic       e_match;
    e_err   = !p[3];
    e_crc   = (e_err || n == 0) ? 3'd0 : model_frame(p, int'(n));
    e_match = e_err ? 1'b0 : (e_crc == ce);
    poly = p; len = n; cexp = ce; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!e_err && n != 0) begin
      for (int k = 0; k < int'(n); k++) begin
        int g;
        g = $urandom_range(gmax, gmin);
        for (int j = 0; j < g; j++) begin
          checks++;
          if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s stall k=%0d: ready=%b done=%b busy=%b, want 1 0 1", name, k, ready, done, busy);
          end
          @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL %s ready k=%0d: got %b, want 1", name, k, ready);
        end
        valid = 1'b1; data = words[k];
        @(posedge clk); #1;
        valid = 1'b0;
        if (k < int'(n) - 1) begin
          checks++;
          if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s early_done k=%0d: got %b, want 0", name, k, done);
          end
        end
      end
    end
    checks++;
    if (done !== 1'b1 || crc !== e_crc || match !== e_match || err !== e_err || ready !== 1'b0) begin
      errors++;
      $display("FAIL %s result: done=%b crc=%b match=%b err=%b ready=%b, want 1 %b %b %b 0",
               name, done, crc, match, err, ready, e_crc, e_match, e_err);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || crc !== e_crc || match !== e_match || err !== e_err) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b crc=%b match=%b err=%b, want 0 0 %b %b %b",
               name, done, busy, crc, match, err, e_crc, e_match, e_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, done, match, err, crc} !== 8'd0) begin
      errors++;
      $display("FAIL reset: ready/busy/done/match/err/crc=%b, want 00000000", {ready, busy, done, match, err, crc});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    words = '{3'b101};
    do_frame("single", 4'b1011, 4'd1, 3'b100, 0, 0);
    checks++;
    if (crc !== 3'b100 || match !== 1'b1) begin
      errors++;
      $display("FAIL single_const: crc=%b match=%b, want 100 1", crc, match);
    end
  endtask

  task automatic test_two();
    words = '{3'b101, 3'b011};
    do_frame("two", 4'b1011, 4'd2, 3'b000, 0, 0);
    checks++;
    if (crc !== 3'b001 || match !== 1'b0) begin
      errors++;
      $display("FAIL two_const: crc=%b match=%b, want 001 0", crc, match);
    end
  endtask

  task automatic test_stalls();
    words = '{3'b101, 3'b011};
    do_frame("stalls", 4'b1011, 4'd2, 3'b001, 3, 3);
  endtask

  task automatic test_illegal_empty();
    words = '{3'b111, 3'b010};
    do_frame("illegal", 4'b0011, 4'd2, 3'b000, 0, 0);
    do_frame("empty_match", 4'b1011, 4'd0, 3'b000, 0, 0);
    do_frame("empty_nomatch", 4'b1101, 4'd0, 3'b101, 0, 0);
  endtask

  task automatic test_abort();
    words = '{3'b101, 3'b011};
    do_frame("abort_pre", 4'b1011, 4'd2, 3'b001, 0, 0);
    poly = 4'b1101; len = 4'd2; cexp = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; data = 3'b110;
    @(posedge clk); #1;
    valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0 || crc !== 3'b001 || match !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: busy=%b ready=%b done=%b crc=%b match=%b err=%b, want 0 0 0 001 0 0",
               busy, ready, done, crc, match, err);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone: done=%b, want 0", done);
    end
    poly = 4'b1011; len = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; data = 3'b101; abort = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || crc !== 3'b001) begin
      errors++;
      $display("FAIL abort_last: busy=%b done=%b crc=%b, want 0 0 001", busy, done, crc);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_last_nodone: done=%b, want 0", done);
    end
    words = '{3'b010, 3'b111, 3'b100};
    do_frame("after_abort", 4'b1001, 4'd3, model_frame(4'b1001, 3), 0, 1);
  endtask

  task automatic test_reset_mid();
    words = '{3'b101, 3'b011};
    do_frame("rst_pre", 4'b1011, 4'd2, 3'b001, 0, 0);
    poly = 4'b1011; len = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; data = 3'b100;
    @(posedge clk); #1;
    valid = 1'b0; start = 1'b1; poly = 4'b0011; len = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: busy=%b ready=%b err=%b done=%b, want 1 1 0 0", busy, ready, err, done);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, match, err, crc} !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: ready/busy/done/match/err/crc=%b, want 00000000", {ready, busy, done, match, err, crc});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || crc !== 3'd0) begin
      errors++;
      $display("FAIL post_reset: busy=%b done=%b crc=%b, want 0 0 000", busy, done, crc);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      logic [3:0] p;
      logic [3:0] n;
      logic [2:0] ce;
      p = {1'b1, 3'($urandom_range(7, 0))};
      n = 4'($urandom_range(8, 0));
      words.delete();
      for (int k = 0; k < int'(n); k++) words.push_back(3'($urandom_range(7, 0)));
      ce = ($urandom_range(1, 0) == 1) ? model_frame(p, int'(n)) : 3'($urandom_range(7, 0));
      do_frame($sformatf("random%0d", f), p, n, ce, 0, 2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_stalls();
    test_illegal_empty();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
